// File: rtl/mipi_pkt_relay_sf.sv
// mipi_pkt_relay_sf: store-and-forward relay from the CSI/DSI packet receiver to the DSI host TX req/ack interface.
// Rev 1.0 -- commit/rollback of long payloads, VC remap and sticky status counters.
`default_nettype none

module mipi_pkt_relay_sf #(
  parameter int          DW      = 32,
  parameter int          CMD_AW  = 4,
  parameter int          DATA_AW = 10,
  parameter logic [7:0]  VC_MAP  = 8'hE4
) (
  input  logic                clkin,
  input  logic                rstn,
  input  logic [23:0]         rx_cmd,
  input  logic                rx_cmd_valid,
  input  logic [DW-1:0]       rx_payload,
  input  logic                rx_payload_valid,
  input  logic                rx_payload_valid_last,
  input  logic                RxActiveHS,
  input  logic                periph_ecc_two_bit_err,
  input  logic                periph_crc_err,
  output logic                req,
  input  logic                ack,
  output logic [1:0]          host_tx_cmd_vc,
  output logic [5:0]          host_tx_cmd_data_type,
  output logic [15:0]         host_tx_cmd_byte_count,
  output logic                host_tx_hs_mode,
  input  logic                host_tx_payload_en,
  input  logic                host_tx_payload_en_last,
  output logic [DW-1:0]       host_tx_payload,
  input  logic                clr_status,
  output logic [15:0]         drop_cnt,
  output logic                ovf_flag,
  output logic                urun_flag,
  output logic [CMD_AW:0]     cmd_level,
  output logic [DATA_AW:0]    data_level
);

  localparam int BPW        = DW / 8;
  localparam int BSH        = $clog2(BPW);
  localparam int CMD_DEPTH  = 1 << CMD_AW;
  localparam int DATA_DEPTH = 1 << DATA_AW;
  localparam logic [CMD_AW:0]  CPTR_ONE = 1;
  localparam logic [DATA_AW:0] DPTR_ONE = 1;
  localparam logic [16:0]      CNT_ONE  = 17'd1;
  localparam logic [16:0]      BPW_M1   = 17'(BPW - 1);

  typedef enum logic [1:0] {R_IDLE, R_LONG, R_CHK, R_DROP} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_REQ, T_PAY} tx_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  // Command entry: {hs, byte_count/short data, vc, data type}
  logic [24:0]        cmd_mem [CMD_DEPTH];
  logic [DW-1:0]      data_mem [DATA_DEPTH];
  logic [CMD_AW:0]    cmd_wr, cmd_rd;
  logic [DATA_AW:0]   wr_ptr, wr_start, commit_ptr, rd_ptr;
  logic [24:0]        hdr_q;
  logic               ovf_mark, crc_seen;
  logic [16:0]        tx_cnt;

  logic        rx_short, rx_word, cmd_full, cmd_empty, data_full;
  logic        cmd_push, cmd_pop, data_we, data_pop, do_commit, do_rollback, hdr_latch;
  logic        ovf_mark_set, rx_drop, proto_drop, ovf_ev, urun_ev, pay_pop;
  logic [24:0] cmd_push_data, cmd_head;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum, head_words;

  assign rx_short  = rx_cmd[5:0] < 6'h10;
  assign rx_word   = rx_payload_valid | rx_payload_valid_last;
  assign cmd_full  = (cmd_wr[CMD_AW] != cmd_rd[CMD_AW]) &&
                     (cmd_wr[CMD_AW-1:0] == cmd_rd[CMD_AW-1:0]);
  assign cmd_empty = (cmd_wr == cmd_rd);
  assign data_full = (wr_ptr[DATA_AW] != rd_ptr[DATA_AW]) &&
                     (wr_ptr[DATA_AW-1:0] == rd_ptr[DATA_AW-1:0]);
  assign cmd_head  = cmd_mem[cmd_rd[CMD_AW-1:0]];
  assign head_words = (cmd_head[5:0] < 6'h10) ? 17'd0
                    : (({1'b0, cmd_head[23:8]} + BPW_M1) >> BSH);

  always_comb begin
    rx_next       = rx_state;
    cmd_push      = 1'b0;
    cmd_push_data = {RxActiveHS, rx_cmd};
    data_we       = 1'b0;
    ovf_mark_set  = 1'b0;
    rx_drop       = 1'b0;
    proto_drop    = 1'b0;
    ovf_ev        = 1'b0;
    do_commit     = 1'b0;
    do_rollback   = 1'b0;
    hdr_latch     = 1'b0;
    case (rx_state)
      R_IDLE: if (rx_cmd_valid) begin
        if (periph_ecc_two_bit_err) begin
          if (rx_short) rx_drop = 1'b1;
          else          rx_next = R_DROP;
        end else if (rx_short) begin
          if (cmd_full) begin
            rx_drop = 1'b1;
            ovf_ev  = 1'b1;
          end else begin
            cmd_push = 1'b1;
          end
        end else begin
          hdr_latch = 1'b1;
          rx_next   = R_LONG;
        end
      end
      R_LONG: begin
        proto_drop = rx_cmd_valid;
        if (rx_word) begin
          if (data_full || ovf_mark) ovf_mark_set = 1'b1;
          else                       data_we      = 1'b1;
        end
        if (rx_payload_valid_last) rx_next = R_CHK;
      end
      R_CHK: begin
        proto_drop = rx_cmd_valid;
        if (crc_seen || periph_crc_err || ovf_mark || cmd_full) begin
          rx_drop     = 1'b1;
          do_rollback = 1'b1;
          ovf_ev      = ovf_mark || cmd_full;
        end else begin
          do_commit     = 1'b1;
          cmd_push      = 1'b1;
          cmd_push_data = hdr_q;
        end
        rx_next = R_IDLE;
      end
      R_DROP: begin
        proto_drop = rx_cmd_valid;
        if (rx_payload_valid_last) rx_next = R_IDLE;
      end
      default: rx_next = R_IDLE;
    endcase
  end

  always_comb begin
    tx_next  = tx_state;
    cmd_pop  = 1'b0;
    data_pop = 1'b0;
    urun_ev  = 1'b0;
    pay_pop  = host_tx_payload_en | host_tx_payload_en_last;
    case (tx_state)
      T_IDLE: if (!cmd_empty) begin
        cmd_pop = 1'b1;
        tx_next = T_REQ;
      end
      T_REQ: if (req && ack) tx_next = (tx_cnt == 17'd0) ? T_IDLE : T_PAY;
      T_PAY: begin
        if (pay_pop) begin
          if (tx_cnt != 17'd0) data_pop = 1'b1;
          else                 urun_ev  = 1'b1;
        end
        if (host_tx_payload_en_last) tx_next = T_IDLE;
      end
      default: tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (cmd_push) cmd_mem[cmd_wr[CMD_AW-1:0]] <= cmd_push_data;
    if (data_we)  data_mem[wr_ptr[DATA_AW-1:0]] <= rx_payload;
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      rx_state   <= R_IDLE;
      cmd_wr     <= '0;
      wr_ptr     <= '0;
      wr_start   <= '0;
      commit_ptr <= '0;
      hdr_q      <= '0;
      ovf_mark   <= 1'b0;
      crc_seen   <= 1'b0;
    end else begin
      rx_state <= rx_next;
      if (cmd_push)  cmd_wr <= cmd_wr + CPTR_ONE;
      if (hdr_latch) begin
        hdr_q    <= {RxActiveHS, rx_cmd};
        wr_start <= wr_ptr;
        ovf_mark <= 1'b0;
        crc_seen <= 1'b0;
      end
      if (ovf_mark_set) ovf_mark <= 1'b1;
      if (rx_state == R_LONG && rx_payload_valid_last) crc_seen <= periph_crc_err;
      if (do_rollback)  wr_ptr <= wr_start;
      else if (data_we) wr_ptr <= wr_ptr + DPTR_ONE;
      if (do_commit) commit_ptr <= wr_ptr;
    end
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      tx_state               <= T_IDLE;
      cmd_rd                 <= '0;
      rd_ptr                 <= '0;
      req                    <= 1'b0;
      tx_cnt                 <= '0;
      host_tx_cmd_vc         <= '0;
      host_tx_cmd_data_type  <= '0;
      host_tx_cmd_byte_count <= '0;
      host_tx_hs_mode        <= 1'b0;
    end else begin
      tx_state <= tx_next;
      req      <= (tx_next == T_REQ);
      if (cmd_pop) begin
        cmd_rd                 <= cmd_rd + CPTR_ONE;
        host_tx_cmd_vc         <= VC_MAP[{cmd_head[7:6], 1'b0} +: 2];
        host_tx_cmd_data_type  <= cmd_head[5:0];
        host_tx_cmd_byte_count <= cmd_head[23:8];
        host_tx_hs_mode        <= cmd_head[24];
        tx_cnt                 <= head_words;
      end
      if (data_pop) begin
        rd_ptr <= rd_ptr + DPTR_ONE;
        tx_cnt <= tx_cnt - CNT_ONE;
      end
    end
  end

  // Status: a same-cycle event takes precedence over clr_status.
  assign drop_inc = {1'b0, rx_drop} + {1'b0, proto_drop};
  assign drop_sum = {1'b0, drop_cnt} + {15'd0, drop_inc};

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      drop_cnt  <= '0;
      ovf_flag  <= 1'b0;
      urun_flag <= 1'b0;
    end else begin
      if (drop_inc != 2'd0) drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      else if (clr_status)  drop_cnt <= '0;
      if (ovf_ev)          ovf_flag <= 1'b1;
      else if (clr_status) ovf_flag <= 1'b0;
      if (urun_ev)         urun_flag <= 1'b1;
      else if (clr_status) urun_flag <= 1'b0;
    end
  end

  assign host_tx_payload = (tx_state == T_PAY && tx_cnt != 17'd0)
                         ? data_mem[rd_ptr[DATA_AW-1:0]] : '0;
  assign cmd_level  = cmd_wr - cmd_rd;
  assign data_level = commit_ptr - rd_ptr;

endmodule

`default_nettype wire

// File: tb/tb_mipi_pkt_relay_sf.sv
// tb_mipi_pkt_relay_sf: scoreboard bench for mipi_pkt_relay_sf (8-word data FIFO, VC_MAP 8'h1B).
`default_nettype none

module tb_mipi_pkt_relay_sf;
  localparam int         DW        = 32;
  localparam int         CMD_AW    = 4;
  localparam int         DATA_AW   = 3;
  localparam logic [7:0] TB_VC_MAP = 8'h1B;

  logic clkin = 1'b0;
  logic rstn;
  logic [23:0] rx_cmd;
  logic rx_cmd_valid, rx_payload_valid, rx_payload_valid_last;
  logic [DW-1:0] rx_payload;
  logic RxActiveHS, periph_ecc_two_bit_err, periph_crc_err;
  logic req, ack;
  logic [1:0] host_tx_cmd_vc;
  logic [5:0] host_tx_cmd_data_type;
  logic [15:0] host_tx_cmd_byte_count;
  logic host_tx_hs_mode, host_tx_payload_en, host_tx_payload_en_last;
  logic [DW-1:0] host_tx_payload;
  logic clr_status;
  logic [15:0] drop_cnt;
  logic ovf_flag, urun_flag;
  logic [CMD_AW:0] cmd_level;
  logic [DATA_AW:0] data_level;

  mipi_pkt_relay_sf #(.DW(DW), .CMD_AW(CMD_AW), .DATA_AW(DATA_AW), .VC_MAP(TB_VC_MAP)) dut (
    .clkin(clkin), .rstn(rstn),
    .rx_cmd(rx_cmd), .rx_cmd_valid(rx_cmd_valid),
    .rx_payload(rx_payload), .rx_payload_valid(rx_payload_valid),
    .rx_payload_valid_last(rx_payload_valid_last), .RxActiveHS(RxActiveHS),
    .periph_ecc_two_bit_err(periph_ecc_two_bit_err), .periph_crc_err(periph_crc_err),
    .req(req), .ack(ack),
    .host_tx_cmd_vc(host_tx_cmd_vc), .host_tx_cmd_data_type(host_tx_cmd_data_type),
    .host_tx_cmd_byte_count(host_tx_cmd_byte_count), .host_tx_hs_mode(host_tx_hs_mode),
    .host_tx_payload_en(host_tx_payload_en), .host_tx_payload_en_last(host_tx_payload_en_last),
    .host_tx_payload(host_tx_payload), .clr_status(clr_status),
    .drop_cnt(drop_cnt), .ovf_flag(ovf_flag), .urun_flag(urun_flag),
    .cmd_level(cmd_level), .data_level(data_level)
  );

  always #5 clkin = ~clkin;

  typedef struct packed {
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] bc;
    logic        hs;
  } hdr_t;

  hdr_t          exp_hdr[$];
  logic [DW-1:0] exp_data[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] remap(input logic [1:0] vc);
    logic [7:0] m;
    m = TB_VC_MAP;
    return m[2*vc +: 2];
  endfunction

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic send_short(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] d,
                            input logic hs, input logic ecc, input logic fwd);
    rx_cmd = {d, vc, dt};
    rx_cmd_valid = 1'b1;
    RxActiveHS = hs;
    periph_ecc_two_bit_err = ecc;
    if (fwd) exp_hdr.push_back('{vc: remap(vc), dt: dt, bc: d, hs: hs});
    tick();
    rx_cmd_valid = 1'b0;
    periph_ecc_two_bit_err = 1'b0;
  endtask

  // Header, nw payload words, then the R_CHK cycle (crc_late raises the CRC error there).
  task automatic send_long(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] bc,
                           input logic hs, input int nw, input logic crc_late,
                           input logic [DW-1:0] base, input logic fwd);
    rx_cmd = {bc, vc, dt};
    rx_cmd_valid = 1'b1;
    RxActiveHS = hs;
    tick();
    rx_cmd_valid = 1'b0;
    for (int i = 0; i < nw; i++) begin
      rx_payload = base + DW'(i);
      rx_payload_valid = 1'b1;
      rx_payload_valid_last = (i == nw - 1);
      if (fwd) exp_data.push_back(base + DW'(i));
      tick();
    end
    rx_payload_valid = 1'b0;
    rx_payload_valid_last = 1'b0;
    periph_crc_err = crc_late;
    tick();
    periph_crc_err = 1'b0;
    if (fwd) exp_hdr.push_back('{vc: remap(vc), dt: dt, bc: bc, hs: hs});
  endtask

  task automatic host_take(input int extra);
    int   w;
    int   nw;
    hdr_t h;
    logic [DW-1:0] e;
    w = 0;
    while (!req && w < 40) begin
      tick();
      w++;
    end
    if (!req) begin
      chk("req_timeout", 64'(req), 64'd1);
      return;
    end
    if (exp_hdr.size() == 0) begin
      chk("unexpected_req", 64'(exp_hdr.size()), 64'd1);
      return;
    end
    h = exp_hdr.pop_front();
    chk("hdr_vc", 64'(host_tx_cmd_vc), 64'(h.vc));
    chk("hdr_dt", 64'(host_tx_cmd_data_type), 64'(h.dt));
    chk("hdr_bc", 64'(host_tx_cmd_byte_count), 64'(h.bc));
    chk("hdr_hs", 64'(host_tx_hs_mode), 64'(h.hs));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("req_after_ack", 64'(req), 64'd0);
    nw = (h.dt < 6'h10) ? 0 : (int'(h.bc) + 3) / 4;
    for (int i = 0; i < nw + extra; i++) begin
      e = '0;
      if (i < nw && exp_data.size() != 0) e = exp_data.pop_front();
      chk("payload", 64'(host_tx_payload), 64'(e));
      host_tx_payload_en = 1'b1;
      host_tx_payload_en_last = (i == nw + extra - 1);
      tick();
    end
    host_tx_payload_en = 1'b0;
    host_tx_payload_en_last = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    rx_cmd = '0; rx_cmd_valid = 1'b0; rx_payload = '0;
    rx_payload_valid = 1'b0; rx_payload_valid_last = 1'b0;
    RxActiveHS = 1'b0; periph_ecc_two_bit_err = 1'b0; periph_crc_err = 1'b0;
    ack = 1'b0; host_tx_payload_en = 1'b0; host_tx_payload_en_last = 1'b0;
    clr_status = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    chk("rst_req", 64'(req), 64'd0);
    chk("rst_cmd_level", 64'(cmd_level), 64'd0);
    chk("rst_data_level", 64'(data_level), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_flags", 64'({ovf_flag, urun_flag}), 64'd0);
    chk("rst_payload", 64'(host_tx_payload), 64'd0);
    chk("rst_vc", 64'(host_tx_cmd_vc), 64'd0);

    // Short packet: req two cycles after the header, VC 1 -> 2 through 8'h1B.
    send_short(6'h01, 2'd1, 16'h1234, 1'b1, 1'b0, 1'b1);
    chk("short_req_early", 64'(req), 64'd0);
    tick();
    chk("short_req_rise", 64'(req), 64'd1);
    chk("short_vc_const", 64'(host_tx_cmd_vc), 64'd2);
    host_take(0);
    chk("short_cmd_level", 64'(cmd_level), 64'd0);
    chk("short_data_level", 64'(data_level), 64'd0);

    // Clean 16-byte long packet.
    send_long(6'h3E, 2'd0, 16'd16, 1'b0, 4, 1'b0, 32'hA000_0000, 1'b1);
    chk("long_commit_level", 64'(data_level), 64'd4);
    host_take(0);
    chk("long_drain_level", 64'(data_level), 64'd0);

    // CRC error in the cycle after the last word: rolled back and counted.
    send_long(6'h3E, 2'd2, 16'd16, 1'b1, 4, 1'b1, 32'hB000_0000, 1'b0);
    repeat (3) tick();
    chk("crc_no_req", 64'(req), 64'd0);
    chk("crc_data_level", 64'(data_level), 64'd0);
    chk("crc_cmd_level", 64'(cmd_level), 64'd0);
    chk("crc_drop_cnt", 64'(drop_cnt), 64'd1);
    send_long(6'h3E, 2'd3, 16'd13, 1'b1, 4, 1'b0, 32'hC000_0000, 1'b1);
    chk("after_crc_level", 64'(data_level), 64'd4);
    host_take(0);

    // 12-word packet into the 8-word data FIFO.
    pulse_clr();
    chk("clr_drop_cnt", 64'(drop_cnt), 64'd0);
    send_long(6'h29, 2'd1, 16'd48, 1'b0, 12, 1'b0, 32'hD000_0000, 1'b0);
    repeat (3) tick();
    chk("ovf_flag", 64'(ovf_flag), 64'd1);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("ovf_no_req", 64'(req), 64'd0);
    chk("ovf_data_level", 64'(data_level), 64'd0);
    send_long(6'h3E, 2'd2, 16'd16, 1'b1, 4, 1'b0, 32'hE000_0000, 1'b1);
    host_take(0);

    // Command FIFO overflow with ack held low: one header is parked in the TX
    // output registers, sixteen fill the FIFO, and the eighteenth is dropped.
    pulse_clr();
    for (int i = 0; i < 18; i++)
      send_short(6'h05, 2'(i % 4), 16'(16'h100 + i), 1'(i % 2), 1'b0, i < 17);
    chk("cmdq_level", 64'(cmd_level), 64'd16);
    chk("cmdq_ovf", 64'(ovf_flag), 64'd1);
    chk("cmdq_drop_cnt", 64'(drop_cnt), 64'd1);
    for (int i = 0; i < 17; i++) host_take(0);
    tick();
    chk("cmdq_drained", 64'(cmd_level), 64'd0);

    // Underrun: five pops on a four-word packet.
    send_long(6'h3E, 2'd0, 16'd16, 1'b0, 4, 1'b0, 32'hF000_0000, 1'b1);
    host_take(1);
    chk("urun_flag", 64'(urun_flag), 64'd1);
    chk("urun_level", 64'(data_level), 64'd0);
    pulse_clr();
    chk("clr_urun", 64'(urun_flag), 64'd0);
    chk("clr_ovf", 64'(ovf_flag), 64'd0);
    chk("clr_drop", 64'(drop_cnt), 64'd0);
    clr_status = 1'b1;
    send_short(6'h02, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
    clr_status = 1'b0;
    chk("clr_vs_drop", 64'(drop_cnt), 64'd1);
    repeat (3) tick();
    chk("ecc_no_req", 64'(req), 64'd0);
    chk("scoreboard_empty", 64'(exp_hdr.size() + exp_data.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
